// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Clocked EX-stage ALU for the multi-cycle MIPS datapath. Single-cycle
//   operations (add/sub/logic/slt/mfhi/mflo) complete one cycle after Start.
//   mult/multu/div/divu run iteratively over WIDTH cycles: shift-add multiply
//   or restoring divide on operand magnitudes, with a fix-up cycle that
//   applies the signs and writes the HI/LO registers.
//
//   State table
//     state  | meaning
//     -------+--------------------------------------------------------------
//     IDLE   | waiting for Start; single-cycle ops execute from here
//     ITER   | one multiply/divide step per cycle, WIDTH cycles in total
//     FIX    | sign correction, HI/LO/Result write, Done raised
//     DONE   | Done cycle; Start is accepted exactly as in IDLE
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   Start           request, sampled only while Busy=0
//   ALUOp, Funct    00 add, 01 sub, 10 decode Funct, 11 reserved
//   A, B            operands (rs, rt)
//   Busy            mul/div in progress (ITER or FIX)
//   Done            one-cycle completion pulse
//   Result          registered result, with ZeroFlag and Overflow
//   DivByZero       with Done when div/divu had B==0
//   High, Low       HI/LO registers
//   WIDTH must be at least 4.
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroFlag,
    output logic             Overflow,
    output logic             DivByZero,
    output logic [WIDTH-1:0] High,
    output logic [WIDTH-1:0] Low
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic               r_dbz;
    logic               r_ov;
    logic               r_zero;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_busy;
    logic               w_accept;

    // ---------------------------------------------------------------
    // Operation decode and single-cycle datapath
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic             w_ov_add;
    logic             w_ov_sub;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ov;
    logic             w_dbz;
    logic             w_md;
    logic             w_md_div;
    logic             w_md_signed;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_sum    = A + B;
    assign w_dif    = A - B;
    assign w_ov_add = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    assign w_ov_sub = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        w_sc_res    = '0;
        w_sc_ov     = 1'b0;
        w_dbz       = 1'b0;
        w_md        = 1'b0;
        w_md_div    = 1'b0;
        w_md_signed = 1'b0;
        case (ALUOp)
            2'b00: begin
                w_sc_res = w_sum;
                w_sc_ov  = w_ov_add;
            end
            2'b01: begin
                w_sc_res = w_dif;
                w_sc_ov  = w_ov_sub;
            end
            2'b10: begin
                case (Funct)
                    6'b100100: w_sc_res = A & B;
                    6'b100101: w_sc_res = A | B;
                    6'b100000: begin
                        w_sc_res = w_sum;
                        w_sc_ov  = w_ov_add;
                    end
                    6'b100010: begin
                        w_sc_res = w_dif;
                        w_sc_ov  = w_ov_sub;
                    end
                    6'b100001: w_sc_res = w_sum;
                    6'b100011: w_sc_res = w_dif;
                    6'b101010: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                    6'b101011: w_sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
                    6'b010000: w_sc_res = r_hi;
                    6'b010010: w_sc_res = r_lo;
                    6'b011000: begin
                        w_md        = 1'b1;
                        w_md_signed = 1'b1;
                    end
                    6'b011001: w_md = 1'b1;
                    6'b011010: begin
                        if (B == '0) begin
                            w_dbz = 1'b1;
                        end else begin
                            w_md        = 1'b1;
                            w_md_div    = 1'b1;
                            w_md_signed = 1'b1;
                        end
                    end
                    6'b011011: begin
                        if (B == '0) begin
                            w_dbz = 1'b1;
                        end else begin
                            w_md     = 1'b1;
                            w_md_div = 1'b1;
                        end
                    end
                    default: w_sc_res = '0;
                endcase
            end
            default: w_sc_res = '0;
        endcase
    end

    // |MIN| reads back as 2^(WIDTH-1) when treated as unsigned, which is exact.
    assign w_mag_a = (w_md_signed && A[WIDTH-1]) ? -A : A;
    assign w_mag_b = (w_md_signed && B[WIDTH-1]) ? -B : B;

    // ---------------------------------------------------------------
    // Iteration step
    //   multiply: r_acc = {partial product, remaining multiplier bits},
    //             r_opb = multiplicand
    //   divide:   r_acc = {partial remainder, dividend/quotient bits},
    //             r_opb = divisor
    // ---------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_div_rs;
    logic [WIDTH:0]     w_div_df;
    logic [2*WIDTH-1:0] w_div_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // The shifted remainder is below 2*divisor, so bit WIDTH of the
    // difference is set exactly when the trial subtraction goes negative.
    assign w_div_rs  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_df  = w_div_rs - {1'b0, r_opb};
    assign w_div_nxt = w_div_df[WIDTH] ? {w_div_rs[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_div_df[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // ---------------------------------------------------------------
    // Sign fix-up
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = (Start && w_md) ? S_ITER : S_IDLE;
            S_ITER:         if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
            S_FIX:          w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state == S_ITER || r_state == S_FIX) begin
            w_busy = 1'b1;
        end
    end

    assign w_accept = Start && !w_busy;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_ov     <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_md) begin
                            r_cnt    <= '0;
                            r_is_div <= w_md_div;
                            r_acc    <= {{WIDTH{1'b0}}, (w_md_div ? w_mag_a : w_mag_b)};
                            r_opb    <= w_md_div ? w_mag_b : w_mag_a;
                            r_neg_q  <= w_md_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_r  <= w_md_signed && A[WIDTH-1];
                        end else begin
                            r_result <= w_sc_res;
                            r_zero   <= (w_sc_res == '0);
                            r_ov     <= w_sc_ov;
                            r_dbz    <= w_dbz;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_result <= w_fix_lo;
                    r_zero   <= (w_fix_lo == '0);
                    r_ov     <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy      = w_busy;
    assign Done      = r_done;
    assign Result    = r_result;
    assign ZeroFlag  = r_zero;
    assign Overflow  = r_ov;
    assign DivByZero = r_dbz;
    assign High      = r_hi;
    assign Low       = r_lo;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Parametrised, clocked successor to the gate-level MIPS ALU. It executes the single-cycle ALU operations and adds iterative multiply and divide, which write dedicated HI/LO registers. It sits in the EX stage of the multi-cycle MIPS datapath and exchanges operands and results with the control FSM through a Start/Busy/Done handshake.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  operation request, sampled only when Busy=0
ALUOp  input  2  00 add, 01 sub, 10 decode Funct, 11 reserved
Funct  input  6  R-type funct field
A  input  WIDTH  operand rs
B  input  WIDTH  operand rt
Busy  output  1  operation in progress
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  registered result
ZeroFlag  output  1  Result==0, registered with Result
Overflow  output  1  signed overflow of add/sub, registered with Result
DivByZero  output  1  set with Done when div/divu has B==0
High  output  WIDTH  HI register
Low  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; counter=0; Busy, Done, Result, ZeroFlag, Overflow, DivByZero, High and Low all 0. An in-flight mul/div is abandoned.
- Funct decode (ALUOp=10): 100100 and, 100101 or, 100000 add, 100010 sub, 100001 addu, 100011 subu, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
- Unknown funct and ALUOp=11: Result=0, Done pulses, HI/LO unchanged.
- FSM states: IDLE, ITER, FIX, DONE.
- Single-cycle ops, division by zero, and unknown ops: at the Start edge, the block registers Result/ZeroFlag/Overflow and sets Done=1 for the next cycle. Busy stays 0. Latency 1.
- Mul/div Start edge: the block latches |A|, |B| (signed ops) or A, B (unsigned ops) and the result signs, clears the counter, sets Busy=1, and moves IDLE->ITER.
- ITER: exactly WIDTH cycles. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring division, one quotient bit per cycle. ITER->FIX when counter==WIDTH-1.
- FIX: one cycle.
  - Apply sign correction: negate the product if the signs differ; quotient sign = sign(A) xor sign(B); remainder takes sign(A); division truncates toward zero.
  - Write High/Low: mult gives {High,Low}=product; div gives Low=quotient, High=remainder.
  - Set Result=Low, ZeroFlag, Done=1, Busy=0. FIX->DONE.
- DONE: Done=1 for one cycle. DONE->IDLE.
- Mul/div latency: Done high in cycle WIDTH+2 after the Start edge.
- Back-to-back issue: Start is accepted again in the Done cycle.
- Start while Busy=1: ignored, with no effect on operands or state.
- Div/divu with B==0: 1-cycle path, DivByZero=1 with Done, Result=0, High/Low unchanged.
- Signed MIN / -1: Low=MIN, High=0, no flag.
- Overflow: set only for signed add/sub (ALUOp 00/01, funct 100000/100010) when operand signs are equal (add) or differ (sub) and the result sign differs from A. Overflow=0 for all other ops. Result is still written.
- Done, DivByZero: 0 in every cycle other than the completion cycle.
- Result, flags, High, Low: hold between operations.
- mfhi/mflo read HI/LO as of the Start edge.

Test Plan:
- WIDTH=32, A=0x87654321, B=0x12345678, Start pulse with ALUOp=00/01 and Funct=100100/100101/101010 -> Result 0x99999999 / 0x7530ECA9 / 0x02244220 / 0x97755779 / 0x00000001, Done one cycle after each Start, Busy never high.
- mult A=0xFFFFFFFD B=7 -> Busy 33 cycles, Done in cycle 34, High=0xFFFFFFFF, Low=0xFFFFFFEB; multu A=B=0xFFFFFFFF -> High=0xFFFFFFFE, Low=0x00000001.
- div A=0xFFFFFFF9 (-7) B=2 -> Low=0xFFFFFFFD, High=0xFFFFFFFF; divu A=100 B=7 -> Low=14, High=2; mflo next -> Result=14.
- div A=5 B=0 -> Done after 1 cycle, DivByZero=1, High/Low unchanged; add A=0x7FFFFFFF B=1 -> Result 0x80000000, Overflow=1; addu same operands -> Overflow=0.
- Start re-asserted with different operands on cycles 5 and 10 of a mult -> ignored, original product delivered; Start on the Done cycle -> accepted.
- rst_n low during cycle 12 of a div -> all outputs 0 immediately (asynchronous); after release, a new add completes normally; WIDTH=8 regression: mult 0xFD*0x07 -> High=0xFF, Low=0xEB, Done in cycle 10.
